// File: rtl/crc_frame_tx.sv
// crc_frame_tx: serial frame transmitter. Shifts a payload out MSB-first,
// computes its CRC bit-serially on the fly and appends it, with optional
// single-bit error injection for exercising the receiver's error path.
module crc_frame_tx #(
    parameter int DATA_W = 64,
    parameter int CRC_W  = 3,
    parameter int CNT_W  = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [CRC_W:0]            crc_poly,
    input  logic                      inj_en,
    input  logic [CNT_W-1:0]          inj_pos,
    output logic                      tx_en,
    output logic                      tx_bit,
    output logic                      tx_sof,
    output logic                      tx_eof,
    output logic                      frame_done,
    output logic [DATA_W+CRC_W-1:0]   frame_out,
    output logic [CRC_W-1:0]          crc_out
);

    localparam int FRAME_W = DATA_W + CRC_W;
    localparam logic [CNT_W-1:0] CNT_FIRST     = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST_DATA = CNT_W'(CRC_W);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC} state_t;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     shreg_q;
    logic [CRC_W-1:0]      poly_q;
    logic                  inj_en_q;
    logic [CNT_W-1:0]      inj_pos_q;
    logic [CRC_W-1:0]      lfsr_q, lfsr_d;
    logic [CRC_W-1:0]      crc_hold_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [FRAME_W-1:0]    frm_q;
    logic [FRAME_W-1:0]    frame_out_q;
    logic [CRC_W-1:0]      crc_out_q;
    logic                  done_q;

    logic accept, inj_hit, data_bit, raw_bit, fb;

    // The polynomial's leading term is implicit in the shift-and-subtract step.
    logic poly_msb_unused;
    assign poly_msb_unused = crc_poly[CRC_W];

    assign accept   = in_valid && (state_q == S_IDLE);
    assign inj_hit  = inj_en_q && (cnt_q == inj_pos_q);
    assign data_bit = shreg_q[DATA_W-1];
    assign fb       = data_bit ^ lfsr_q[CRC_W-1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: payload bits down to index CRC_W, then CRC bits down to 0
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)                 state_d = S_DATA;
            S_DATA:  if (cnt_q == CNT_LAST_DATA) state_d = S_CRC;
            S_CRC:   if (cnt_q == '0)            state_d = S_IDLE;
            default:                             state_d = S_IDLE;
        endcase
    end

    // Outputs: serial bit is the clean bit XOR the injection hit
    always_comb begin
        in_ready = (state_q == S_IDLE);
        tx_en    = (state_q != S_IDLE);
        raw_bit  = 1'b0;
        if (state_q == S_DATA)     raw_bit = data_bit;
        else if (state_q == S_CRC) raw_bit = lfsr_q[CRC_W-1];
        tx_bit   = tx_en & (raw_bit ^ inj_hit);
        tx_sof   = (state_q == S_DATA) && (cnt_q == CNT_FIRST);
        tx_eof   = (state_q == S_CRC)  && (cnt_q == '0);
    end

    // LFSR step: divide by the polynomial during payload, plain shift-out during CRC
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == S_DATA)
            lfsr_d = {lfsr_q[CRC_W-2:0], 1'b0} ^ (fb ? poly_q : '0);
        else if (state_q == S_CRC)
            lfsr_d = {lfsr_q[CRC_W-2:0], 1'b0};
    end

    // Datapath: capture at accept, shift while sending, publish results at end of frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            poly_q      <= '0;
            inj_en_q    <= 1'b0;
            inj_pos_q   <= '0;
            lfsr_q      <= '0;
            crc_hold_q  <= '0;
            cnt_q       <= '0;
            frm_q       <= '0;
            frame_out_q <= '0;
            crc_out_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (accept) begin
                    shreg_q   <= in_data;
                    poly_q    <= crc_poly[CRC_W-1:0];
                    inj_en_q  <= inj_en;
                    inj_pos_q <= inj_pos;
                    lfsr_q    <= '0;
                    cnt_q     <= CNT_FIRST;
                end
                S_DATA: begin
                    shreg_q <= shreg_q << 1;
                    lfsr_q  <= lfsr_d;
                    cnt_q   <= cnt_q - 1'b1;
                    frm_q   <= {frm_q[FRAME_W-2:0], tx_bit};
                    // The LFSR holds the true CRC right after the last payload bit;
                    // keep a copy since the CRC phase shifts it away.
                    if (cnt_q == CNT_LAST_DATA) crc_hold_q <= lfsr_d;
                end
                S_CRC: begin
                    lfsr_q <= lfsr_d;
                    frm_q  <= {frm_q[FRAME_W-2:0], tx_bit};
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        done_q      <= 1'b1;
                        frame_out_q <= {frm_q[FRAME_W-2:0], tx_bit};
                        crc_out_q   <= crc_hold_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign frame_done = done_q;
    assign frame_out  = frame_out_q;
    assign crc_out    = crc_out_q;

endmodule
